// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- port bundle for the multi-port register file.
//   wEn/write_sel/write_data : NUM_WRITE write ports, port k in slice k
//   read_sel                 : NUM_READ read selects, port j in slice j
//   read_data/read_busy      : combinational read results per read port
//   rsv_en/rsv_sel           : scoreboard reservation request
// Modports: master = issue/writeback side, slave = the register file.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  logic [NUM_WRITE-1:0]            wEn;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_sel;
  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data;
  logic [NUM_READ*ADDR_WIDTH-1:0]  read_sel;
  logic [NUM_READ*DATA_WIDTH-1:0]  read_data;
  logic [NUM_READ-1:0]             read_busy;
  logic                            rsv_en;
  logic [ADDR_WIDTH-1:0]           rsv_sel;

  modport master (
    output wEn, write_sel, write_data, read_sel, rsv_en, rsv_sel,
    input  read_data, read_busy
  );

  modport slave (
    input  wEn, write_sel, write_data, read_sel, rsv_en, rsv_sel,
    output read_data, read_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file with a
// per-register busy scoreboard.
//   clock : rising-edge clock
//   reset : asynchronous active-high; clears registers and busy bits and
//           forces all read outputs to zero while high
//   bus   : regfile_mp_if slave (write ports, read ports, reservation)
// Writes land on the clock edge (highest-index port wins on a shared
// target) and clear the target's busy bit; a reservation on the same
// register in the same cycle overrides that clear. Reads are combinational,
// optionally forwarding same-cycle writes (BYPASS). With ZERO_REG, register
// 0 reads zero/not-busy and drops writes and reservations.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic         clock,
  input logic         reset,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]      busy_r;

  logic [ADDR_WIDTH-1:0] wsel_s  [NUM_WRITE];
  logic [DATA_WIDTH-1:0] wdata_s [NUM_WRITE];
  logic                  wkeep_s [NUM_WRITE];
  logic                  rsv_keep_s;
  logic [ADDR_WIDTH-1:0] rsel_s  [NUM_READ];
  logic [DATA_WIDTH-1:0] rdata_s [NUM_READ];
  logic                  rbusy_s [NUM_READ];
  logic                  rhit_s  [NUM_READ];

  // Unpack write ports and drop anything aimed at a hardwired-zero register 0.
  always_comb begin
    for (int k = 0; k < NUM_WRITE; k++) begin
      wsel_s[k]  = bus.write_sel[k*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_s[k] = bus.write_data[k*DATA_WIDTH +: DATA_WIDTH];
      if ((ZERO_REG != 0) && (wsel_s[k] == {ADDR_WIDTH{1'b0}})) begin
        wkeep_s[k] = 1'b0;
      end else begin
        wkeep_s[k] = bus.wEn[k];
      end
    end
    if ((ZERO_REG != 0) && (bus.rsv_sel == {ADDR_WIDTH{1'b0}})) begin
      rsv_keep_s = 1'b0;
    end else begin
      rsv_keep_s = bus.rsv_en;
    end
  end

  // Storage and scoreboard update; later ports override earlier ones, and
  // the reservation is applied last so a new producer beats a retiring one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wkeep_s[k]) begin
          regs_r[wsel_s[k]] <= wdata_s[k];
          busy_r[wsel_s[k]] <= 1'b0;
        end
      end
      if (rsv_keep_s) begin
        busy_r[bus.rsv_sel] <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    bus.read_data = {(NUM_READ*DATA_WIDTH){1'b0}};
    bus.read_busy = {NUM_READ{1'b0}};
    for (int j = 0; j < NUM_READ; j++) begin
      rsel_s[j]  = bus.read_sel[j*ADDR_WIDTH +: ADDR_WIDTH];
      rdata_s[j] = regs_r[rsel_s[j]];
      rbusy_s[j] = busy_r[rsel_s[j]];
      rhit_s[j]  = 1'b0;
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WRITE; k++) begin
          if (wkeep_s[k] && (wsel_s[k] == rsel_s[j])) begin
            rhit_s[j]  = 1'b1;
            rdata_s[j] = wdata_s[k];
          end else begin
            rhit_s[j]  = rhit_s[j];
          end
        end
      end else begin
        rhit_s[j] = 1'b0;
      end
      // A forwarded write retires the producer unless a new one is issued now.
      if (rhit_s[j]) begin
        rbusy_s[j] = rsv_keep_s && (bus.rsv_sel == rsel_s[j]);
      end else begin
        rbusy_s[j] = busy_r[rsel_s[j]];
      end
      if (reset || ((ZERO_REG != 0) && (rsel_s[j] == {ADDR_WIDTH{1'b0}}))) begin
        bus.read_data[j*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
        bus.read_busy[j] = 1'b0;
      end else begin
        bus.read_data[j*DATA_WIDTH +: DATA_WIDTH] = rdata_s[j];
        bus.read_busy[j] = rbusy_s[j];
      end
    end
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, the next-generation register file for the pipelined core. It provides NUM_READ combinational read ports and NUM_WRITE clocked write ports, with optional same-cycle write-to-read bypass and a hardwired-zero register 0. The scoreboard lets issue logic mark a destination register as pending and see that status on every read port. It sits between decode/issue (read, reserve) and writeback (write).

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, select width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..8)
- NUM_WRITE, 2, number of write ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is forwarded to read ports; 0 = reads see stored value only
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and reservations
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all registers and busy bits
- wEn  input  NUM_WRITE  per-port write enable
- write_sel  input  NUM_WRITE*ADDR_WIDTH  port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- write_data  input  NUM_WRITE*DATA_WIDTH  port k at [k*DATA_WIDTH +: DATA_WIDTH]
- read_sel  input  NUM_READ*ADDR_WIDTH  port j select
- read_data  output  NUM_READ*DATA_WIDTH  port j data
- read_busy  output  NUM_READ  port j: selected register has an outstanding reservation
- rsv_en  input  1  reserve (mark busy) register rsv_sel this cycle
- rsv_sel  input  ADDR_WIDTH  register to reserve

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops; busy vector of 2**ADDR_WIDTH bits.
- Write: on rising clock, for each k with wEn[k]=1, reg[write_sel_k] <= write_data_k. Same target on several ports: highest-index port wins. Write also clears busy[write_sel_k].
- Reserve: on rising clock with rsv_en=1, busy[rsv_sel] <= 1. Set and clear on the same register in the same cycle: set wins (new producer issued while the old one retires).
- Read (combinational): read_data_j = reg[read_sel_j]. With BYPASS=1, if any port k has wEn[k]=1 and write_sel_k == read_sel_j, read_data_j = write_data of the highest such k, and read_busy_j = 0 (unless rsv_en targets the same register, in which case read_busy_j = 1).
- read_busy_j = busy[read_sel_j] otherwise.
- ZERO_REG=1: read of select 0 returns 0 and read_busy 0 regardless of writes/bypass; writes and reservations of 0 are dropped.
- No state machine beyond the storage and scoreboard; no handshake; every port is valid every cycle.

## Timing
- Reset asserted (any time, asynchronously): all registers = 0, all busy = 0 immediately; read_data = 0 and read_busy = 0 on all ports while reset is high; writes, reservations and bypass are suppressed while reset is high.
- Reset deasserted: first write is captured on the first rising edge where reset is low.
- Write latency: stored value visible on read ports the cycle after the edge (BYPASS=0); same cycle as wEn (BYPASS=1).
- Reserve latency: read_busy rises the cycle after the edge with rsv_en (BYPASS=0); same cycle when bypass forwarding is active and rsv_sel matches.
- Read ports are purely combinational from read_sel and state; no read enable.
- Reset mid-write cycle: the pending write is lost; register reads 0.

## Test plan
- Reset with all read_sel=0..3 random: read_data all 0x00000000, read_busy all 0; hold 2 cycles, still 0.
- Port 0 write reg 2 = 0xDEADBEEF, then read_sel0=read_sel1=2: both ports 0xDEADBEEF next cycle; BYPASS=1 also shows it combinationally in the write cycle.
- Ports 0 and 1 both write reg 5 (0x11111111, 0x22222222) in the same cycle: reg 5 reads 0x22222222.
- Write reg 0 = 0xFFFFFFFF and reserve reg 0 with ZERO_REG=1: read_data 0, read_busy 0.
- Reserve reg 7: read_busy=1 on a port selecting 7; write reg 7 = 0x12345678: busy clears, data 0x12345678; reserve and write reg 7 in the same cycle: busy stays 1, data updated.
- Write reg 9 = 0xA5A5A5A5, assert reset asynchronously mid-cycle between edges: read_data for reg 9 drops to 0 before the next edge; busy bits all 0.
